// File: rtl/divisor_seq_pkg.sv
// rtl/divisor_seq_pkg.sv - shared constants and state encoding for the sequential divider
package divisor_seq_pkg;

  // Operand width: the divisor, quotient and remainder are all this wide.
  // The dividend is twice as wide.
  localparam int OP_W = 16;

  // Number of restoring steps, one per quotient bit.
  localparam int N_STEPS = 16;

  // Width of the step counter.
  localparam int CNT_W = $clog2(N_STEPS);

  // Width of the partial-remainder compare/subtract, which is one bit wider than an operand.
  localparam int SUB_W = OP_W + 1;

  // Width of the working register: the dividend plus one guard bit.
  localparam int P_W = 2 * OP_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DIV   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Returns the counter value at which the final restoring step runs.
  function automatic logic [CNT_W-1:0] last_step();
    return CNT_W'(N_STEPS - 1);
  endfunction

endpackage

// File: rtl/Subtractor.sv
// rtl/Subtractor.sv - combinational 17-bit unsigned compare/subtract
//
// Purpose : computes i_a - i_b and reports whether i_a >= i_b.
// Ports   : i_a         minuend (17 bits)
//           i_b         subtrahend (17 bits)
//           o_diff      i_a - i_b, modulo 2^17
//           o_no_borrow 1 when i_a >= i_b (unsigned)
module Subtractor
  import divisor_seq_pkg::*;
(
  input  logic [SUB_W-1:0] i_a,
  input  logic [SUB_W-1:0] i_b,
  output logic [SUB_W-1:0] o_diff,
  output logic             o_no_borrow
);

  // The extra top bit of the widened subtraction is the borrow out.
  logic [SUB_W:0] w_full;

  assign w_full      = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff      = w_full[SUB_W-1:0];
  assign o_no_borrow = ~w_full[SUB_W];

endmodule

// File: rtl/divisor_seq.sv
// rtl/divisor_seq.sv - sequential 32/16 restoring divider with overflow detection
//
// Purpose : divides a 32-bit unsigned dividend by a 16-bit unsigned divisor,
//           one quotient bit per cycle, and flags an overflow when the quotient
//           would not fit in 16 bits or the divisor is zero.
// Ports   : i_clk        clock, rising edge
//           i_rst        synchronous active-high reset
//           i_st         start request, sampled only in IDLE
//           i_dividendo  dividend, captured on an accepted start
//           i_divisor    divisor, captured on an accepted start
//           o_quociente  quotient, valid from o_done until the next accepted start
//           o_resto      remainder, with the same validity as o_quociente
//           o_v          overflow flag, with the same validity as o_quociente
//           o_idle       high only in IDLE
//           o_done       high only in DONE, for exactly one cycle
module divisor_seq
  import divisor_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_st,
  input  logic [2*OP_W-1:0] i_dividendo,
  input  logic [OP_W-1:0]   i_divisor,
  output logic [OP_W-1:0]   o_quociente,
  output logic [OP_W-1:0]   o_resto,
  output logic              o_v,
  output logic              o_idle,
  output logic              o_done
);

  state_t r_state;
  state_t w_state_next;

  logic [P_W-1:0]   r_p;
  logic [OP_W-1:0]  r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_q;
  logic [OP_W-1:0]  r_r;
  logic             r_v;

  logic [SUB_W-1:0] w_sub_a;
  logic [SUB_W-1:0] w_sub_b;
  logic [SUB_W-1:0] w_diff;
  logic             w_no_borrow;
  logic [P_W-1:0]   w_p_shift;
  logic [P_W-1:0]   w_p_step;
  logic             w_last;

  // One subtractor is shared by the overflow check and the restoring steps.
  // In CHECK it compares the upper dividend half (P[32] is still zero) with D;
  // in DIV it compares the upper part of P as it will be after the left shift.
  assign w_sub_a = (r_state == S_CHECK) ? r_p[P_W-1:OP_W] : r_p[P_W-2:OP_W-1];
  assign w_sub_b = {1'b0, r_d};

  Subtractor u_subtractor (
    .i_a         (w_sub_a),
    .i_b         (w_sub_b),
    .o_diff      (w_diff),
    .o_no_borrow (w_no_borrow)
  );

  // One restoring step: shift left, then subtract D from the top 17 bits and
  // shift in a quotient 1 when it fits, otherwise keep the shifted value and
  // shift in a 0.
  assign w_p_shift = {r_p[P_W-2:0], 1'b0};

  always_comb begin
    w_p_step = w_p_shift;
    if (w_no_borrow) begin
      w_p_step = {w_diff, w_p_shift[OP_W-1:1], 1'b1};
    end
  end

  assign w_last = (r_cnt == last_step());

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_st) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        // P[31:16] >= D also catches D == 0.
        w_state_next = w_no_borrow ? S_DONE : S_DIV;
      end
      S_DIV: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_v   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_st) begin
            r_p   <= {1'b0, i_dividendo};
            r_d   <= i_divisor;
            r_cnt <= '0;
            r_v   <= 1'b0;
          end
        end
        S_CHECK: begin
          if (w_no_borrow) begin
            r_v <= 1'b1;
            r_q <= '0;
            r_r <= '0;
          end
        end
        S_DIV: begin
          r_p   <= w_p_step;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_q <= w_p_step[OP_W-1:0];
            r_r <= w_p_step[2*OP_W-1:OP_W];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_quociente = r_q;
  assign o_resto     = r_r;
  assign o_v         = r_v;
  assign o_idle      = (r_state == S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule
